// File: rtl/alu_issuer.sv
// Initiator-side controller for a combinational ALU: accepts a request, holds the
// ALU inputs for SETTLE cycles, captures the result and returns it over a handshake.
module alu_issuer #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic [2:0]       rsp_op,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       complete;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign capture   = (state == ST_SETTLE) && (settle_cnt == 4'd1);
  assign complete  = (state == ST_RESP) && rsp_ready;
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == 4'd1) state_next = ST_RESP;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ALU inputs change only on accept; the response fields only on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      settle_cnt <= '0;
      rsp_res    <= '0;
      rsp_op     <= '0;
      rsp_zero   <= 1'b0;
      rsp_valid  <= 1'b0;
      done_cnt   <= '0;
    end else begin
      if (accept) begin
        alu_a      <= req_a;
        alu_b      <= req_b;
        alu_op     <= req_op;
        settle_cnt <= 4'(SETTLE);
      end
      if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (capture) begin
        rsp_res   <= alu_res;
        rsp_op    <= alu_op;
        rsp_zero  <= (alu_res == '0);
        rsp_valid <= 1'b1;
      end
      if (complete) begin
        rsp_valid <= 1'b0;
        done_cnt  <= done_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
Initiator-side controller for the 32-bit combinational ALU (ports A, B, ALU_operation, res).
- Accepts operation requests over a valid/ready handshake and drives the ALU operand and opcode inputs.
- Holds those inputs stable for a programmable settle time, then captures res.
- Returns the result, a zero flag and the opcode over a second valid/ready handshake.
- Sits between a sequencer or CPU datapath and the ALU, replacing hand-driven stimulus.

Parameters:
WIDTH, 32, operand and result width.
SETTLE, 1, number of cycles the ALU inputs are held before res is sampled; legal range 1..15.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_a  input  WIDTH  operand A.
req_b  input  WIDTH  operand B.
req_op  input  3  ALU_operation code, passed through without interpretation.
alu_a  output  WIDTH  to ALU A.
alu_b  output  WIDTH  to ALU B.
alu_op  output  3  to ALU ALU_operation.
alu_res  input  WIDTH  from ALU res.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_res  output  WIDTH  captured ALU result.
rsp_op  output  3  opcode that produced rsp_res.
rsp_zero  output  1  high when rsp_res == 0.
busy  output  1  high in any state other than IDLE.
done_cnt  output  CNT_W  count of completed response handshakes.

Behaviour:
Reset (rst_n low, asynchronous):
- State goes to IDLE.
- alu_a, alu_b, alu_op, rsp_res, rsp_op, rsp_zero, rsp_valid, done_cnt and the settle counter are all 0.
- req_ready is 1 once in IDLE; busy is 0.

FSM states: IDLE, SETTLE, RESP.

IDLE:
- req_ready = 1.
- On a clock edge with req_valid=1: load alu_a/alu_b/alu_op from req_a/req_b/req_op, load the settle counter with SETTLE, and go to SETTLE.
- If req_valid=0, remain in IDLE; outputs unchanged.

SETTLE:
- req_ready = 0; ALU inputs held stable.
- The counter decrements each edge.
- On the edge where the counter equals 1: rsp_res <= alu_res, rsp_op <= alu_op, rsp_zero <= (alu_res == 0), rsp_valid <= 1, and go to RESP.

RESP:
- req_ready = 0; rsp_valid = 1.
- rsp_res, rsp_op and rsp_zero are stable until the handshake.
- On an edge with rsp_ready=1: rsp_valid <= 0, done_cnt <= done_cnt + 1 (wraps modulo 2^CNT_W, no saturation), go to IDLE.
- rsp_ready is ignored outside RESP.

Latency and throughput:
- An accept at edge k raises rsp_valid at edge k+SETTLE.
- The earliest next accept is the edge after the response handshake, so one request is in flight at a time.
- Peak throughput is one operation per SETTLE+2 cycles.

Signal rules:
- alu_a, alu_b and alu_op keep their last values after the response; they change only on accept or reset.
- req_a, req_b and req_op are sampled only on the accept edge; changes at other times have no effect.
- Simultaneous rsp_ready and req_valid in RESP: only the response completes. The request is taken in IDLE on the following edge if req_valid is still high.
- rsp_ready held high permanently: the response completes on the edge after rsp_valid rises.
- Reset asserted mid-SETTLE or mid-RESP: immediate return to IDLE, rsp_valid drops asynchronously, the pending result is discarded, and done_cnt is cleared.
- busy = (state != IDLE), decoded combinationally from state.

Test Plan:
Bench ALU stub for all tests: res = A + B, combinational, independent of op; SETTLE = 1 unless stated.

1. Accept a=A5A5A5A5, b=5A5A5A5A, op=7 at edge k -> alu_op=7 after edge k; at edge k+1 rsp_valid=1, rsp_res=FFFFFFFF, rsp_op=7, rsp_zero=0; after handshake, done_cnt=1.
2. a=0, b=12345678 (decimal), then a=87654321, b=12345678, rsp_ready tied high -> responses 12345678 then 99999999; req_ready=0 from accept through RESP; rsp_valid high exactly one cycle each.
3. a=F1111110, b=0EEEEEEF with rsp_ready held low for 5 cycles -> rsp_res=FFFFFFFF stays stable and rsp_valid stays high; a new req_valid in this window is not accepted; after the handshake, the request is accepted in IDLE.
4. a=FFFFFFFF, b=00000001 -> rsp_res=00000000, rsp_zero=1.
5. SETTLE=4: accept at edge k -> rsp_valid rises at edge k+4; changing req_a during SETTLE leaves alu_a unchanged.
6. Pulse rst_n low during SETTLE, then during RESP with done_cnt=3 -> rsp_valid, done_cnt and the alu_* outputs go to 0 asynchronously; req_ready=1 after release; the next request completes normally. Run CNT_W=2 for five handshakes -> done_cnt wraps 3→0→1.
